// File: rtl/uram_pkg.sv
// Shared types and helpers for the URAM tile reader.
package uram_pkg;

  // Reader control states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } rdr_state_t;

  // Per-element stream tags, captured when the read is issued.
  typedef struct packed {
    logic eot;
    logic last;
  } sideband_t;

  // Element-address width for a memory of the given depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry fall-through FIFO. When empty, a pushed word is visible on dout in the
// same cycle, so a read returning this cycle can be consumed without an extra stage.
module stream_fifo2 #(
  parameter int unsigned W = 10
) (
  input  logic         clkA,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot [2];
  logic         wrPtr;
  logic         rdPtr;
  logic         passThru;
  logic         wrEn;
  logic         rdEn;

  // Storage control and head selection; a word popped in the cycle it arrives into an
  // empty FIFO is never stored.
  always_comb begin
    passThru = push && (count == 2'd0) && pop;
    wrEn     = push && !passThru;
    rdEn     = pop && (count != 2'd0);
    valid    = (count != 2'd0) || push;
    if (count != 2'd0) begin
      dout = slot[rdPtr];
    end else if (push) begin
      dout = din;
    end else begin
      dout = '0;
    end
  end

  // Pointer and occupancy update; when full, a pop frees the slot being overwritten.
  always_ff @(posedge clkA) begin
    if (rst) begin
      count <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else begin
      if (wrEn) begin
        slot[wrPtr] <= din;
        wrPtr       <= ~wrPtr;
      end
      if (rdEn) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + {1'b0, wrEn} - {1'b0, rdEn};
    end
  end

endmodule

// File: rtl/uram_tile_reader.sv
// Walks a 2-D tile in row-major order, reads it from the packed-URAM port B and
// streams the elements out with row-end and tile-end tags.
module uram_tile_reader
  import uram_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 512,
  parameter  int unsigned DIMW  = 10,
  localparam int unsigned AW    = addr_w(DEPTH)
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    cfg_base,
  input  logic [DIMW-1:0]  cfg_rows,
  input  logic [DIMW-1:0]  cfg_cols,
  input  logic [AW-1:0]    cfg_stride,
  output logic             busy,
  output logic             done,
  output logic             mem_enB,
  output logic [AW-1:0]    mem_addrB,
  input  logic [WIDTH-1:0] mem_doutB,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             m_eot,
  input  logic             m_ready
);

  rdr_state_t      state;
  logic [DIMW-1:0] rowsQ;
  logic [DIMW-1:0] colsQ;
  logic [AW-1:0]   strideQ;
  logic [DIMW-1:0] r;
  logic [DIMW-1:0] c;
  logic [AW-1:0]   rowBase;
  logic            inflight;
  sideband_t       tagQ;

  logic            pop;
  logic            isLastCol;
  logic            isEot;
  logic [1:0]      fifoCount;
  logic [WIDTH+1:0] fifoDout;

  assign pop = m_valid && m_ready;
  assign {m_eot, m_last, m_data} = fifoDout;

  // Issue decision and address; credit counts buffered plus in-flight elements so the
  // two-entry buffer can never overflow, while a same-cycle pop keeps one per cycle.
  always_comb begin
    isLastCol = (c == colsQ - DIMW'(1));
    isEot     = isLastCol && (r == rowsQ - DIMW'(1));
    mem_enB   = (state == ISSUE) &&
                (({1'b0, fifoCount} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    mem_addrB = rowBase + AW'(c);
  end

  // Control FSM, tile walk and the one-stage tag pipe aligned with the read latency.
  always_ff @(posedge clkA) begin
    if (rst) begin
      state    <= IDLE;
      rowsQ    <= '0;
      colsQ    <= '0;
      strideQ  <= '0;
      r        <= '0;
      c        <= '0;
      rowBase  <= '0;
      inflight <= 1'b0;
      tagQ     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= mem_enB;
      if (mem_enB) begin
        tagQ <= '{eot: isEot, last: isLastCol};
      end
      case (state)
        IDLE: begin
          if (start) begin
            rowsQ   <= cfg_rows;
            colsQ   <= cfg_cols;
            strideQ <= cfg_stride;
            rowBase <= cfg_base;
            r       <= '0;
            c       <= '0;
            busy    <= 1'b1;
            state   <= ((cfg_rows == '0) || (cfg_cols == '0)) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (mem_enB) begin
            if (isLastCol) begin
              c       <= '0;
              r       <= r + DIMW'(1);
              rowBase <= rowBase + strideQ;
            end else begin
              c <= c + DIMW'(1);
            end
            if (isEot) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The eot beat is the last one pushed, so its acceptance means fully drained.
          if (pop && m_eot) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          // Entered with done already set after a drain; zero-size tiles pulse here.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_fifo2 #(
    .W(WIDTH + 2)
  ) u_fifo (
    .clkA  (clkA),
    .rst   (rst),
    .push  (inflight),
    .din   ({tagQ, mem_doutB}),
    .pop   (pop),
    .valid (m_valid),
    .dout  (fifoDout),
    .count (fifoCount)
  );

endmodule

// File: tb/tb_uram_tile_reader.sv
// Self-checking bench for uram_tile_reader: behavioural memory, tile-walk reference model.
module tb_uram_tile_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned DIMW  = 10;
  localparam int unsigned AW    = 9;

  logic             clkA = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    cfg_base;
  logic [DIMW-1:0]  cfg_rows;
  logic [DIMW-1:0]  cfg_cols;
  logic [AW-1:0]    cfg_stride;
  logic             busy;
  logic             done;
  logic             mem_enB;
  logic [AW-1:0]    mem_addrB;
  logic [WIDTH-1:0] mem_doutB = '0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_eot;
  logic             m_ready;

  logic [WIDTH-1:0] memArr [DEPTH];

  typedef struct {
    logic [WIDTH-1:0] d;
    bit               last;
    bit               eot;
  } beat_t;

  beat_t         expQ [$];
  logic [AW-1:0] addrQ [$];

  int passed = 0;
  int total  = 0;

  uram_tile_reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .DIMW (DIMW)
  ) dut (
    .clkA      (clkA),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .cfg_stride(cfg_stride),
    .busy      (busy),
    .done      (done),
    .mem_enB   (mem_enB),
    .mem_addrB (mem_addrB),
    .mem_doutB (mem_doutB),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_eot     (m_eot),
    .m_ready   (m_ready)
  );

  always #5 clkA = ~clkA;

  // Memory port B: one-cycle read latency.
  always @(posedge clkA) begin
    if (mem_enB) mem_doutB <= memArr[mem_addrB];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one tile from start to done. strict: m_ready held high, beats must be back-to-back.
  task automatic run_tile(input int base, input int rows, input int cols, input int stride,
                          input int readyPct, input int holdFrom, input int secondAt,
                          input bit strict);
    int          issued;
    int          accepted;
    int          beats;
    int          lastAcc;
    int          nBeats;
    bit          seenDone;
    bit          prevStall;
    bit          popNow;
    logic [10:0] prevOut;
    beat_t       e;

    expQ.delete();
    addrQ.delete();
    // Reference: row-major walk, address (base + r*stride + c) mod DEPTH.
    for (int rr = 0; rr < rows; rr++) begin
      for (int cc = 0; cc < cols; cc++) begin
        int a;
        a = (base + rr * stride + cc) % DEPTH;
        addrQ.push_back(AW'(a));
        expQ.push_back('{memArr[a], cc == cols - 1, (cc == cols - 1) && (rr == rows - 1)});
      end
    end
    nBeats    = expQ.size();
    issued    = 0;
    accepted  = 0;
    beats     = 0;
    lastAcc   = -100;
    seenDone  = 1'b0;
    prevStall = 1'b0;
    prevOut   = '0;

    for (int k = 0; k < 400 && !seenDone; k++) begin
      @(negedge clkA);
      start = (k == 0) || (k == secondAt);
      if (k == 0) begin
        cfg_base   = AW'(base);
        cfg_rows   = DIMW'(rows);
        cfg_cols   = DIMW'(cols);
        cfg_stride = AW'(stride);
      end else if (k == secondAt) begin
        cfg_base   = AW'(base + 77);
        cfg_rows   = DIMW'(2);
        cfg_cols   = DIMW'(1);
        cfg_stride = AW'(5);
      end
      if (holdFrom >= 0 && k >= holdFrom && k < holdFrom + 10) m_ready = 1'b0;
      else m_ready = ($urandom_range(99) < 32'(readyPct));
      #1;
      popNow = m_valid && m_ready;
      if (prevStall) check("stall_hold", {m_valid, m_eot, m_last, m_data}, prevOut);
      if (k == 1) check("busy_after_start", busy, 1);
      if (mem_enB) begin
        check("credit", ((issued - accepted - int'(popNow)) < 2) ? 1 : 0, 1);
        if (addrQ.size() == 0) check("extra_read", 1, 0);
        else check("read_addr", mem_addrB, addrQ.pop_front());
        issued++;
      end
      if (popNow) begin
        if (expQ.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = expQ.pop_front();
          check("beat_data", m_data, e.d);
          check("beat_last", m_last, e.last);
          check("beat_eot", m_eot, e.eot);
          if (strict) check("beat_time", k, 2 + beats);
          if (e.eot) lastAcc = k;
        end
        beats++;
        accepted++;
      end
      if (done) begin
        seenDone = 1'b1;
        if (nBeats == 0) check("done_time_zero", k, 2);
        else check("done_time", k, lastAcc + 1);
        check("busy_at_done", busy, 0);
      end
      prevStall = m_valid && !m_ready;
      prevOut   = {m_valid, m_eot, m_last, m_data};
    end
    if (!seenDone) check("done_timeout", 0, 1);
    check("beats_left", expQ.size(), 0);
    check("reads_left", addrQ.size(), 0);
    // Quiet after completion: no second done, no stray traffic.
    repeat (3) begin
      @(negedge clkA);
      start   = 1'b0;
      m_ready = 1'b1;
      #1;
      check("idle_quiet", {done, m_valid, mem_enB}, 0);
    end
  endtask

  initial begin
    void'($urandom(32'd20240611));
    for (int a = 0; a < DEPTH; a++) memArr[a] = WIDTH'(a);
    rst        = 1'b1;
    start      = 1'b0;
    m_ready    = 1'b1;
    cfg_base   = '0;
    cfg_rows   = '0;
    cfg_cols   = '0;
    cfg_stride = '0;

    // Reset state.
    repeat (3) @(negedge clkA);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enB", mem_enB, 0);
    check("rst_addrB", mem_addrB, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_eot", m_eot, 0);
    @(negedge clkA);
    rst = 1'b0;

    // Basic tile: expect 0,1,2,8,9,10.
    run_tile(0, 2, 3, 8, 100, -1, -1, 1'b1);
    // Same tile under random backpressure plus a 10-cycle stall.
    run_tile(0, 2, 3, 8, 50, 3, -1, 1'b0);
    // Address wrap: 510, 511, 0, 1.
    run_tile(510, 1, 4, 0, 100, -1, -1, 1'b1);
    // Zero-size tiles.
    run_tile(7, 0, 5, 3, 100, -1, -1, 1'b0);
    run_tile(7, 5, 0, 3, 100, -1, -1, 1'b0);
    // Second start while busy is ignored.
    run_tile(20, 4, 4, 7, 70, -1, 5, 1'b0);

    // Reset after the third beat of a 4x4 tile.
    @(negedge clkA);
    cfg_base   = AW'(40);
    cfg_rows   = DIMW'(4);
    cfg_cols   = DIMW'(4);
    cfg_stride = AW'(16);
    start      = 1'b1;
    m_ready    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clkA);
      start = 1'b0;
    end
    @(negedge clkA);
    rst     = 1'b1;
    m_ready = 1'b0;
    @(negedge clkA);
    rst = 1'b0;
    #1;
    check("midrst_outputs",
          {busy, done, mem_enB, mem_addrB, m_valid, m_data, m_last, m_eot}, 0);
    repeat (6) begin
      @(negedge clkA);
      m_ready = 1'b1;
      #1;
      check("midrst_no_done", {done, busy, m_valid, mem_enB}, 0);
    end
    run_tile(40, 4, 4, 16, 100, -1, -1, 1'b1);

    // Randomized tiles over random memory contents.
    for (int a = 0; a < DEPTH; a++) memArr[a] = WIDTH'($urandom);
    for (int t = 0; t < 6; t++) begin
      run_tile(int'($urandom_range(DEPTH - 1)), int'($urandom_range(5, 1)),
               int'($urandom_range(6, 1)), int'($urandom_range(DEPTH - 1)), 60, -1, -1,
               1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
